// File: rtl/traffic_light_fsm_if.sv
// Bundle of the traffic controller's data-side signals.
// There is no valid/ready handshake here. clk_1hz and ped_req are level inputs
// that the controller samples on every clk_50mhz edge. All outputs are registered
// state, and a consumer may read them on any cycle.
interface traffic_light_fsm_if;
    logic       clk_1hz;    // toggling 1 Hz timebase, treated as data
    logic       ped_req;    // pedestrian button, level or pulse
    logic [2:0] ns_light;   // {red,yellow,green} for the NS road
    logic [2:0] ew_light;   // {red,yellow,green} for the EW road
    logic       walk;       // pedestrian walk lamp
    logic       ped_wait;   // request latched, not yet served
    logic [7:0] sec_left;   // seconds remaining in the current phase
    logic [2:0] state_dbg;  // current FSM state encoding, for checkers

    // The master side drives the timebase and the button, and observes the lamps.
    modport master (
        output clk_1hz, ped_req,
        input  ns_light, ew_light, walk, ped_wait, sec_left, state_dbg
    );

    // The slave side is the controller itself.
    modport slave (
        input  clk_1hz, ped_req,
        output ns_light, ew_light, walk, ped_wait, sec_left, state_dbg
    );
endinterface

// File: rtl/traffic_light_fsm.sv
// Two-road intersection controller running on clk_50mhz.
// Every rising edge of the 1 Hz timebase becomes a one-cycle seconds tick.
// The controller sequences green, yellow and all-red clearance phases for the
// NS and EW roads, plus a latched pedestrian walk phase. It also publishes the
// seconds left in the current phase.
module traffic_light_fsm #(
    parameter int unsigned GREEN_S  = 10,
    parameter int unsigned YELLOW_S = 3,
    parameter int unsigned ALLRED_S = 1,
    parameter int unsigned WALK_S   = 5
) (
    input  logic                clk_50mhz,
    input  logic                rst,
    traffic_light_fsm_if.slave  bus
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5,
        WALK = 3'd6
    } state_t;

    localparam logic [7:0] GREEN_T  = 8'(GREEN_S);
    localparam logic [7:0] YELLOW_T = 8'(YELLOW_S);
    localparam logic [7:0] ALLRED_T = 8'(ALLRED_S);
    localparam logic [7:0] WALK_T   = 8'(WALK_S);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t     state;
    state_t     next_state;
    logic       clk_1hz_d;
    logic       tick;
    logic       phase_end;
    logic [7:0] sec_left;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_wait;

    // Phase length loaded into sec_left on entry to state s.
    function automatic logic [7:0] phase_len(input state_t s);
        case (s)
            NS_G, EW_G: phase_len = GREEN_T;
            NS_Y, EW_Y: phase_len = YELLOW_T;
            AR1, AR2:   phase_len = ALLRED_T;
            WALK:       phase_len = WALK_T;
            default:    phase_len = GREEN_T;
        endcase
    endfunction

    // Lamp pattern {ns, ew, walk} shown while in state s.
    function automatic logic [6:0] phase_lamps(input state_t s);
        case (s)
            NS_G:    phase_lamps = {LAMP_G, LAMP_R, 1'b0};
            NS_Y:    phase_lamps = {LAMP_Y, LAMP_R, 1'b0};
            AR1:     phase_lamps = {LAMP_R, LAMP_R, 1'b0};
            EW_G:    phase_lamps = {LAMP_R, LAMP_G, 1'b0};
            EW_Y:    phase_lamps = {LAMP_R, LAMP_Y, 1'b0};
            AR2:     phase_lamps = {LAMP_R, LAMP_R, 1'b0};
            WALK:    phase_lamps = {LAMP_R, LAMP_R, 1'b1};
            default: phase_lamps = {LAMP_G, LAMP_R, 1'b0};
        endcase
    endfunction

    // A rising edge of the timebase, seen in the cycle it first reads high.
    assign tick      = bus.clk_1hz & ~clk_1hz_d;
    assign phase_end = tick && (sec_left == 8'd1);

    // Phase order. The walk phase is inserted after AR2 only when a request is pending.
    always_comb begin
        next_state = state;
        case (state)
            NS_G:    next_state = NS_Y;
            NS_Y:    next_state = AR1;
            AR1:     next_state = EW_G;
            EW_G:    next_state = EW_Y;
            EW_Y:    next_state = AR2;
            AR2:     next_state = ped_wait ? WALK : NS_G;
            WALK:    next_state = NS_G;
            default: next_state = NS_G;
        endcase
    end

    // Controller state, phase timer, registered lamps and pedestrian latch.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state     <= NS_G;
            sec_left  <= GREEN_T;
            ns_light  <= LAMP_G;
            ew_light  <= LAMP_R;
            walk      <= 1'b0;
            ped_wait  <= 1'b0;
            // Starting high means a timebase already high at release is not an edge.
            clk_1hz_d <= 1'b1;
        end else begin
            clk_1hz_d <= bus.clk_1hz;
            if (bus.ped_req) begin
                ped_wait <= 1'b1;
            end
            if (phase_end) begin
                state                        <= next_state;
                sec_left                     <= phase_len(next_state);
                {ns_light, ew_light, walk}   <= phase_lamps(next_state);
                // Entering WALK serves the request. A press in that same cycle is served too.
                if (next_state == WALK) begin
                    ped_wait <= 1'b0;
                end
            end else if (tick) begin
                sec_left <= sec_left - 8'd1;
            end
        end
    end

    assign bus.ns_light  = ns_light;
    assign bus.ew_light  = ew_light;
    assign bus.walk      = walk;
    assign bus.ped_wait  = ped_wait;
    assign bus.sec_left  = sec_left;
    assign bus.state_dbg = state;

endmodule
